// File: rtl/enc_lag3_multi.sv
// Multi-channel pitch-lag index encoder: per-channel search window, first/second
// subframe index coding, four-state sequencer with a one-cycle done pulse.
module enc_lag3_multi #(
   parameter int NUM_CH       = 2,
   parameter int CH_W         = 1,
   parameter int PIT_MIN      = 20,
   parameter int PIT_MAX      = 143,
   parameter int LAG_THRESH   = 85,
   parameter int IDX_OFS_LO   = 58,
   parameter int IDX_OFS_HI   = 112,
   parameter int SEARCH_HALF  = 5,
   parameter int SEARCH_RANGE = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [CH_W-1:0] ch,
   input  logic [15:0]     T0,
   input  logic [15:0]     T0_frac,
   input  logic [15:0]     pit_flag,
   input  logic            ld_en,
   input  logic [CH_W-1:0] ld_ch,
   input  logic [15:0]     ld_min,
   input  logic [15:0]     ld_max,
   output logic            done,
   output logic [15:0]     index,
   output logic [15:0]     T0_min_out,
   output logic [15:0]     T0_max_out,
   output logic            range_err
);

   localparam int NSLOT = 1 << CH_W;

   localparam logic [15:0] RST_MIN   = 16'(PIT_MIN);
   localparam logic [15:0] RST_MAX   = 16'(PIT_MIN + SEARCH_RANGE);
   localparam logic [15:0] HI_MIN    = 16'(PIT_MAX - SEARCH_RANGE);
   localparam logic [15:0] HI_MAX    = 16'(PIT_MAX);
   localparam logic [15:0] U_THRESH  = 16'(LAG_THRESH);
   localparam logic [15:0] U_OFS_LO  = 16'(IDX_OFS_LO);
   localparam logic [15:0] U_OFS_HI  = 16'(IDX_OFS_HI);
   localparam logic [15:0] U_RANGE   = 16'(SEARCH_RANGE);

   localparam logic signed [17:0] W_HALF  = 18'(SEARCH_HALF);
   localparam logic signed [17:0] W_PMIN  = 18'(PIT_MIN);
   localparam logic signed [17:0] W_PMAX  = 18'(PIT_MAX);
   localparam logic signed [17:0] W_RANGE = 18'(SEARCH_RANGE);

   typedef enum logic [1:0] {IDLE, CALC, LIMIT, DONE} state_t;

   // Clamp a signed lag offset into 0..SEARCH_RANGE; the result always fits 16 bits.
   function automatic logic [15:0] sat_offset(input logic signed [17:0] v);
      if (v < 18'sd0)
         return 16'd0;
      else if (v > W_RANGE)
         return U_RANGE;
      else
         return v[15:0];
   endfunction

   function automatic logic offset_clipped(input logic signed [17:0] v);
      return (v < 18'sd0) || (v > W_RANGE);
   endfunction

   state_t                 state_q, state_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [15:0]            t0_q, t0_d;
   logic [15:0]            frac_q, frac_d;
   logic                   sub2_q, sub2_d;
   logic [15:0]            idx_q, idx_d;
   logic [15:0]            min_q, min_d;
   logic [15:0]            max_q, max_d;
   logic                   over_q, over_d;
   logic                   err_q, err_d;

   logic [15:0]            win_min_q [NSLOT];
   logic [15:0]            win_min_d [NSLOT];
   logic [15:0]            win_max_q [NSLOT];
   logic [15:0]            win_max_d [NSLOT];

   logic                   done_q, done_d;
   logic [15:0]            index_q, index_d;
   logic [15:0]            min_out_q, min_out_d;
   logic [15:0]            max_out_q, max_out_d;
   logic                   range_err_q, range_err_d;

   logic signed [17:0]     t0_w;
   logic signed [17:0]     lo_w;
   logic signed [17:0]     f_min_w;
   logic signed [17:0]     f_max_w;
   logic signed [17:0]     diff_w;
   logic [15:0]            f_idx;
   logic [15:0]            s_off;
   logic [15:0]            s_idx;
   logic                   cap_ok;
   logic                   ld_ok;

   // Index and window arithmetic for the captured request; 18-bit signed keeps
   // small lags from wrapping when the window's low side is subtracted.
   always_comb begin
      t0_w    = signed'({2'b00, t0_q});
      lo_w    = t0_w - W_HALF;
      f_min_w = (lo_w < W_PMIN) ? W_PMIN : lo_w;
      f_max_w = f_min_w + W_RANGE;
      if (t0_q <= U_THRESH)
         f_idx = t0_q + t0_q + t0_q - U_OFS_LO + frac_q;
      else
         f_idx = t0_q + U_OFS_HI;
      diff_w  = t0_w - signed'({2'b00, win_min_q[ch_q]});
      s_off   = sat_offset(diff_w);
      s_idx   = s_off + s_off + s_off + 16'd2 + frac_q;
      cap_ok  = int'(ch_q) < NUM_CH;
      ld_ok   = int'(ld_ch) < NUM_CH;
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      t0_d        = t0_q;
      frac_d      = frac_q;
      sub2_d      = sub2_q;
      idx_d       = idx_q;
      min_d       = min_q;
      max_d       = max_q;
      over_d      = over_q;
      err_d       = err_q;
      win_min_d   = win_min_q;
      win_max_d   = win_max_q;
      done_d      = 1'b0;
      index_d     = index_q;
      min_out_d   = min_out_q;
      max_out_d   = max_out_q;
      range_err_d = range_err_q;

      case (state_q)
         IDLE: begin
            if (ld_en) begin
               if (ld_ok) begin
                  win_min_d[ld_ch] = ld_min;
                  win_max_d[ld_ch] = ld_max;
               end
            end else if (start) begin
               ch_d    = ch;
               t0_d    = T0;
               frac_d  = T0_frac;
               sub2_d  = |pit_flag;
               state_d = CALC;
            end
         end
         CALC: begin
            if (sub2_q) begin
               idx_d  = s_idx;
               min_d  = win_min_q[ch_q];
               max_d  = win_max_q[ch_q];
               over_d = 1'b0;
               err_d  = offset_clipped(diff_w);
            end else begin
               idx_d  = f_idx;
               min_d  = f_min_w[15:0];
               max_d  = f_max_w[15:0];
               over_d = f_max_w > W_PMAX;
               err_d  = 1'b0;
            end
            state_d = LIMIT;
         end
         LIMIT: begin
            if (over_q) begin
               min_d = HI_MIN;
               max_d = HI_MAX;
            end
            // Only a first subframe moves the channel window.
            if (!sub2_q && cap_ok) begin
               win_min_d[ch_q] = over_q ? HI_MIN : min_q;
               win_max_d[ch_q] = over_q ? HI_MAX : max_q;
            end
            state_d = DONE;
         end
         DONE: begin
            done_d      = 1'b1;
            index_d     = idx_q;
            min_out_d   = min_q;
            max_out_d   = max_q;
            range_err_d = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         index_q     <= 16'd0;
         min_out_q   <= RST_MIN;
         max_out_q   <= RST_MAX;
         range_err_q <= 1'b0;
         for (int k = 0; k < NSLOT; k++) begin
            win_min_q[k] <= RST_MIN;
            win_max_q[k] <= RST_MAX;
         end
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         index_q     <= index_d;
         min_out_q   <= min_out_d;
         max_out_q   <= max_out_d;
         range_err_q <= range_err_d;
         win_min_q   <= win_min_d;
         win_max_q   <= win_max_d;
      end
   end

   // Request capture and intermediate results are qualified by the sequencer state.
   always_ff @(posedge clk) begin
      ch_q   <= ch_d;
      t0_q   <= t0_d;
      frac_q <= frac_d;
      sub2_q <= sub2_d;
      idx_q  <= idx_d;
      min_q  <= min_d;
      max_q  <= max_d;
      over_q <= over_d;
      err_q  <= err_d;
   end

   assign done       = done_q;
   assign index      = index_q;
   assign T0_min_out = min_out_q;
   assign T0_max_out = max_out_q;
   assign range_err  = range_err_q;

endmodule

// File: tb/tb_enc_lag3_multi.sv
// Self-checking bench for enc_lag3_multi: directed vector table, corner-case
// sequences, and randomized traffic against a lag-coding reference model.
module tb_enc_lag3_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [0:0]  ch;
   logic [15:0] T0;
   logic [15:0] T0_frac;
   logic [15:0] pit_flag;
   logic        ld_en;
   logic [0:0]  ld_ch;
   logic [15:0] ld_min;
   logic [15:0] ld_max;
   logic        done;
   logic [15:0] index;
   logic [15:0] T0_min_out;
   logic [15:0] T0_max_out;
   logic        range_err;

   int n_cmp = 0;
   int n_bad = 0;
   int m_min [2];
   int m_max [2];

   enc_lag3_multi dut (
      .clk(clk), .reset(reset), .start(start), .ch(ch), .T0(T0),
      .T0_frac(T0_frac), .pit_flag(pit_flag), .ld_en(ld_en), .ld_ch(ld_ch),
      .ld_min(ld_min), .ld_max(ld_max), .done(done), .index(index),
      .T0_min_out(T0_min_out), .T0_max_out(T0_max_out), .range_err(range_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ld;
      int c;
      int t;
      int f;
      int p;
      int lmin;
      int lmax;
      int ei;
      int emin;
      int emax;
      int eerr;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_min[k] = 20;
         m_max[k] = 29;
      end
   endtask

   // Lag coding rules in plain integer arithmetic.
   task automatic model_enc(input int c, input int t, input int f, input int p,
                            output int ei, output int emin, output int emax, output int eerr);
      int i;
      if (p == 0) begin
         emin = (t - 5 < 20) ? 20 : t - 5;
         emax = emin + 9;
         if (emax > 143) begin
            emax = 143;
            emin = 134;
         end
         ei   = (t <= 85) ? 3 * t - 58 + f : t + 112;
         eerr = 0;
         m_min[c] = emin;
         m_max[c] = emax;
      end else begin
         i    = t - m_min[c];
         eerr = (i < 0 || i > 9) ? 1 : 0;
         if (i < 0) i = 0;
         if (i > 9) i = 9;
         ei   = 3 * i + 2 + f;
         emin = m_min[c];
         emax = m_max[c];
      end
      ei = ei & 32'hFFFF;
   endtask

   task automatic do_load(input int c, input int lmin, input int lmax);
      @(negedge clk);
      ld_en  = 1'b1;
      ld_ch  = 1'(c);
      ld_min = 16'(lmin);
      ld_max = 16'(lmax);
      @(negedge clk);
      ld_en  = 1'b0;
      m_min[c] = lmin & 32'hFFFF;
      m_max[c] = lmax & 32'hFFFF;
   endtask

   // Issues one request and watches five cycles after the sampling edge.
   // With stray set, a second start is held high while the first is in flight.
   task automatic encode(input int c, input int t, input int f, input int p, input bit stray,
                         output int first, output int cnt);
      @(negedge clk);
      start    = 1'b1;
      ch       = 1'(c);
      T0       = 16'(t);
      T0_frac  = 16'(f);
      pit_flag = (p != 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      first = -1;
      cnt   = 0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            cnt++;
            if (first < 0) first = k;
         end
         if (stray && k == 1) begin
            start = 1'b1;
            T0    = 16'(t + 7);
         end
         if (k == 2) start = 1'b0;
      end
   endtask

   task automatic check_outs(input string tag, input int ei, input int emin, input int emax, input int eerr);
      chk({tag, "_index"}, 32'(index), 32'(ei));
      chk({tag, "_min"}, 32'(T0_min_out), 32'(emin));
      chk({tag, "_max"}, 32'(T0_max_out), 32'(emax));
      chk({tag, "_err"}, 32'(range_err), 32'(eerr));
   endtask

   task automatic run_model_txn(input string tag, input int c, input int t, input int f, input int p);
      int first, cnt, ei, emin, emax, eerr;
      encode(c, t, f, p, 1'b0, first, cnt);
      model_enc(c, t, f, p, ei, emin, emax, eerr);
      chk({tag, "_lat"}, 32'(first), 32'd3);
      chk({tag, "_cnt"}, 32'(cnt), 32'd1);
      check_outs(tag, ei, emin, emax, eerr);
   endtask

   initial begin
      int first, cnt, ei, emin, emax, eerr, held;

      tbl[0]  = '{0, 0,  60,  1, 0,  0,  0, 123,  55,  64, 0};
      tbl[1]  = '{0, 0, 100,  0, 0,  0,  0, 212,  95, 104, 0};
      tbl[2]  = '{0, 0,  22, -1, 0,  0,  0,   7,  20,  29, 0};
      tbl[3]  = '{0, 0, 140,  0, 0,  0,  0, 252, 134, 143, 0};
      tbl[4]  = '{1, 1,   0,  0, 0, 55, 64,   0,   0,   0, 0};
      tbl[5]  = '{0, 1,  57, -1, 1,  0,  0,   7,  55,  64, 0};
      tbl[6]  = '{0, 1,  70,  0, 1,  0,  0,  29,  55,  64, 1};
      tbl[7]  = '{0, 0, 136,  0, 1,  0,  0,   8, 134, 143, 0};
      tbl[8]  = '{0, 0, 130,  1, 1,  0,  0,   3, 134, 143, 1};
      tbl[9]  = '{0, 0,   3,  0, 0,  0,  0, 65487, 20, 29, 0};
      tbl[10] = '{0, 0,  85,  0, 0,  0,  0, 197,  80,  89, 0};
      tbl[11] = '{0, 0,  86,  0, 0,  0,  0, 198,  81,  90, 0};
      tbl[12] = '{0, 0, 138,  0, 0,  0,  0, 250, 133, 142, 0};
      tbl[13] = '{0, 0, 139,  0, 0,  0,  0, 251, 134, 143, 0};

      reset = 1'b1; start = 1'b0; ch = '0; T0 = '0; T0_frac = '0; pit_flag = '0;
      ld_en = 1'b0; ld_ch = '0; ld_min = '0; ld_max = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      check_outs("rst", 0, 20, 29, 0);
      reset = 1'b0;

      for (int v = 0; v < 14; v++) begin
         if (tbl[v].ld) begin
            do_load(tbl[v].c, tbl[v].lmin, tbl[v].lmax);
         end else begin
            encode(tbl[v].c, tbl[v].t, tbl[v].f, tbl[v].p, 1'b0, first, cnt);
            model_enc(tbl[v].c, tbl[v].t, tbl[v].f, tbl[v].p, ei, emin, emax, eerr);
            chk($sformatf("tbl%0d_lat", v), 32'(first), 32'd3);
            chk($sformatf("tbl%0d_cnt", v), 32'(cnt), 32'd1);
            check_outs($sformatf("tbl%0d", v), tbl[v].ei, tbl[v].emin, tbl[v].emax, tbl[v].eerr);
         end
      end

      // Stray start while busy must not spawn a second request.
      encode(0, 60, 1, 0, 1'b1, first, cnt);
      model_enc(0, 60, 1, 0, ei, emin, emax, eerr);
      chk("stray_lat", 32'(first), 32'd3);
      chk("stray_cnt", 32'(cnt), 32'd1);
      check_outs("stray", ei, emin, emax, eerr);
      for (int k = 0; k < 4; k++) @(negedge clk);
      chk("stray_idle", 32'(done), 32'd0);

      // Load and start together: the load wins and outputs hold.
      held = int'(index);
      @(negedge clk);
      ld_en = 1'b1; start = 1'b1; ld_ch = 1'b0; ld_min = 16'd100; ld_max = 16'd109;
      ch = 1'b0; T0 = 16'd60; T0_frac = 16'd0; pit_flag = 16'd0;
      @(negedge clk);
      ld_en = 1'b0; start = 1'b0;
      m_min[0] = 100; m_max[0] = 109;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("ldwin_nodone", 32'(cnt), 32'd0);
      chk("ldwin_hold", 32'(index), 32'(held));
      run_model_txn("ldwin_use", 0, 104, 0, 1);

      // Reset one cycle into a request aborts it.
      @(negedge clk);
      start = 1'b1; ch = 1'b1; T0 = 16'd100; T0_frac = 16'd0; pit_flag = 16'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      check_outs("abort", 0, 20, 29, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("abort_nodone", 32'(cnt), 32'd0);
      run_model_txn("post_rst0", 0, 20, 0, 1);
      run_model_txn("post_rst1", 1, 29, 1, 1);
      run_model_txn("post_rst2", 1, 60, 1, 0);

      for (int n = 0; n < 150; n++) begin
         int c, t, f, p;
         c = int'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) begin
            t = int'($urandom_range(0, 160));
            do_load(c, t, t + 9);
         end else begin
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 200));
            f = int'($urandom_range(0, 2)) - 1;
            p = int'($urandom_range(0, 1));
            run_model_txn($sformatf("rnd%0d", n), c, t, f, p);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/enc_lag3_multi.md
ENC_LAG3_MULTI -- requirements
Module: enc_lag3_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent encoder channels.
REQ-002 SHALL have parameter CH_W, default 1: channel-select width; NUM_CH <= 2^CH_W.
REQ-003 SHALL have parameter PIT_MIN, default 20: minimum pitch lag.
REQ-004 SHALL have parameter PIT_MAX, default 143: maximum pitch lag.
REQ-005 SHALL have parameter LAG_THRESH, default 85: upper lag for fractional coding, first subframe.
REQ-006 SHALL have parameter IDX_OFS_LO, default 58: fractional-region index offset.
REQ-007 SHALL have parameter IDX_OFS_HI, default 112: integer-region index offset.
REQ-008 SHALL have parameter SEARCH_HALF, default 5: lag window low side.
REQ-009 SHALL have parameter SEARCH_RANGE, default 9: lag window span, T0_max - T0_min.
REQ-010 clk  input  1: single clock; all state changes on its rising edge.
REQ-011 reset  input  1: asynchronous, active-high reset.
REQ-012 start  input  1: request; sampled only in IDLE.
REQ-013 ch  input  CH_W: channel to encode; captured with start.
REQ-014 T0  input  16: integer pitch lag, unsigned; captured with start.
REQ-015 T0_frac  input  16: signed fractional lag, -1/0/+1; captured with start.
REQ-016 pit_flag  input  16: zero = first subframe, nonzero = second; captured with start.
REQ-017 ld_en  input  1: test preload strobe for ld_ch window, IDLE only.
REQ-018 ld_ch  input  CH_W: channel to preload.
REQ-019 ld_min  input  16: preload value for T0_min.
REQ-020 ld_max  input  16: preload value for T0_max.
REQ-021 done  output  1: one-cycle completion pulse.
REQ-022 index  output  16: encoded lag index.
REQ-023 T0_min_out  output  16: T0_min of the last encoded channel after update.
REQ-024 T0_max_out  output  16: T0_max of the last encoded channel after update.
REQ-025 range_err  output  1: second-subframe lag fell outside the window.

Function
REQ-026 SHALL keep a per-channel register pair {T0_min, T0_max}; channels never affect each other.
REQ-027 FSM states IDLE, CALC, LIMIT, DONE; IDLE->CALC on start; CALC->LIMIT->DONE->IDLE unconditionally.
REQ-028 done SHALL go high exactly 3 cycles after the edge sampling start, for one cycle.
REQ-029 start outside IDLE SHALL be ignored; ld_en outside IDLE SHALL be ignored; ld_en and start together in IDLE: ld_en wins, start ignored.
REQ-030 First subframe, T0 <= LAG_THRESH: index = 3*T0 - IDX_OFS_LO + T0_frac, 16-bit two's complement.
REQ-031 First subframe, T0 > LAG_THRESH: index = T0 + IDX_OFS_HI.
REQ-032 First subframe window: T0_min = max(T0 - SEARCH_HALF, PIT_MIN); T0_max = T0_min + SEARCH_RANGE.
REQ-033 If T0_max > PIT_MAX: T0_max = PIT_MAX and T0_min = PIT_MAX - SEARCH_RANGE; written back in LIMIT.
REQ-034 Second subframe: i = T0 - T0_min(ch), clamped to 0..SEARCH_RANGE; index = 3*i + 2 + T0_frac; window unchanged.
REQ-035 range_err SHALL be 1 iff the clamp in REQ-034 was active; it is 0 for first subframes.
REQ-036 index, T0_min_out, T0_max_out, range_err SHALL update in DONE and hold until the next DONE.
REQ-037 Window compare SHALL be signed 17-bit, so T0 < SEARCH_HALF cannot wrap.

Reset
REQ-038 reset SHALL force IDLE at once, mid-operation included; the aborted request produces no done.
REQ-039 On reset: done=0, index=0, range_err=0, T0_min_out=PIT_MIN, T0_max_out=PIT_MIN+SEARCH_RANGE.
REQ-040 On reset every channel SHALL hold T0_min=PIT_MIN and T0_max=PIT_MIN+SEARCH_RANGE.

Verification
REQ-041 ch0, T0=60, frac=+1, pit_flag=0 -> done after 3 cycles; index=123, T0_min_out=55, T0_max_out=64.
REQ-042 T0=100, frac=0, pit_flag=0 -> index=212, window 95/104; T0=22, frac=-1 -> index=7, window 20/29.
REQ-043 T0=140, frac=0, pit_flag=0 -> index=252, window 134/143 via high clamp.
REQ-044 ld ch1 min=55 max=64, then ch1, T0=57, frac=-1, pit_flag=1 -> index=7, range_err=0.
REQ-045 Then ch1, T0=70, frac=0, pit_flag=1 -> index=29, range_err=1; ch0 window unchanged.
REQ-046 Assert reset one cycle after start -> no done pulse; all outputs and channel windows at reset values; a new start completes normally.
